// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit:
// state enum, opcodes, ALUOp and datapath mux encodings.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_FAULT
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_type(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_type = IMM_S;
      OP_BRANCH: imm_type = IMM_B;
      OP_JAL:    imm_type = IMM_J;
      OP_LUI:    imm_type = IMM_U;
      default:   imm_type = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/op[5]/funct7[5] to an ALU control code.
module mc_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               alu_op,
  input  logic [2:0]           funct3,
  input  logic                 op5,
  input  logic                 funct7_5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] ctl;

  always_comb begin
    ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      default: begin
        case (funct3)
          // only register-register ops carry a subtract; addi ignores funct7
          3'b000:  ctl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctl = ALU_SLT;
          3'b110:  ctl = ALU_OR;
          3'b111:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign alu_control = ALUCTRL_W'(ctl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM sharing one memory port and one ALU.
// Define MCU_BRANCH_EXT_EN to also accept bne (funct3 001) in BRANCH.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W      = 3,
  parameter int IMMSRC_W       = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [IMMSRC_W-1:0]  imm_src,
  output logic                 reg_write,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 fault
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_req_i, pc_write_i, ir_write_i, reg_write_i, mem_write_i;
  logic             waiting, timeout_hit;
  aluop_e           alu_op;

  assign waiting     = mem_req_i & ~mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    mem_req_i   = 1'b0;
    pc_write_i  = 1'b0;
    ir_write_i  = 1'b0;
    reg_write_i = 1'b0;
    mem_write_i = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_i  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_i = mem_ready;
        pc_write_i = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_i = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_i = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_i   = 1'b1;
        mem_write_i = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_i = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_i = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        state_d   = S_FETCH;
        if (funct3 == 3'b000) pc_write_i = zero;
`ifdef MCU_BRANCH_EXT_EN
        else if (funct3 == 3'b001) pc_write_i = ~zero;
`endif
        else state_d = S_FAULT;
      end
      S_LUI: begin
        result_src  = RES_IMMEXT;
        reg_write_i = 1'b1;
        state_d     = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    // a ready in the final allowed cycle still completes normally
    if (timeout_hit) state_d = S_FAULT;

    if (state_d != state_q) wait_cnt_d = '0;
    else if (waiting)       wait_cnt_d = wait_cnt_q + 1'b1;
    else                    wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  assign mem_req   = mem_req_i & rst_n;
  assign pc_write  = pc_write_i & rst_n;
  assign ir_write  = ir_write_i & rst_n;
  assign reg_write = reg_write_i & rst_n;
  assign mem_write = mem_write_i & rst_n;
  assign imm_src   = IMMSRC_W'(imm_type(op));
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected control sequences built from
// the instruction-level behaviour, compared cycle by cycle against the DUT.
module tb_multicycle_control_unit;

  localparam int TO = 4;
`ifdef MCU_BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
  logic [18:0] obs;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [18:0] exp; logic rdy; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .ALUCTRL_W(3), .IMMSRC_W(3), .TIMEOUT_CYCLES(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_write(reg_write), .alu_control(alu_control),
    .fault(fault)
  );

  assign obs = {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, fault,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0110111) return 3'b100;
    return 3'b000;
  endfunction

  // ALU result for an R/I-type instruction: add/sub/slt/or/and
  function automatic logic [2:0] rtype_alu(input logic [2:0] f3, input logic op5,
                                           input logic f75);
    if (f3 == 3'b000) return (op5 && f75) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  task automatic push(input logic mreq, pcw, adr, mw, irw, rw, flt,
                      input logic [1:0] rs, a, b, input logic [2:0] alu,
                      input logic rdy);
    ent_t e;
    e.exp = {mreq, pcw, adr, mw, irw, rw, flt, rs, a, b, alu, imm_ref(op)};
    e.rdy = rdy;
    q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push_fault();
    push(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, rnd());
  endtask

  // Expected cycle sequence for the instruction currently on op/funct3/funct7_5/zero.
  // df/dm: cycles mem_ready stays low in the fetch / data access.
  task automatic model_instr(input int df, input int dm);
    logic legal, take;
    for (int i = 0; i < df; i++) push(1,0,0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 1'b0);
    push(1,1,0,0,1,0,0, 2'b10,2'b00,2'b10, 3'b000, 1'b1);
    push(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, rnd());
    case (op)
      7'b0000011: begin
        push(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, rnd());
        for (int i = 0; i < dm; i++) push(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1'b0);
        push(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1'b1);
        push(0,0,0,0,0,1,0, 2'b01,2'b00,2'b00, 3'b000, rnd());
      end
      7'b0100011: begin
        push(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, rnd());
        for (int i = 0; i < dm; i++) push(1,0,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1'b0);
        push(1,0,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1'b1);
      end
      7'b0110011, 7'b0010011: begin
        push(0,0,0,0,0,0,0, 2'b00,2'b10, (op == 7'b0010011) ? 2'b01 : 2'b00,
             rtype_alu(funct3, op[5], funct7_5), rnd());
        push(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, rnd());
      end
      7'b1100011: begin
        legal = (funct3 == 3'b000) || (EXT && funct3 == 3'b001);
        take  = (funct3 == 3'b000) ? zero : ~zero;
        push(0, legal & take,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b001, rnd());
        if (!legal) push_fault();
      end
      7'b1101111: begin
        push(0,1,0,0,0,0,0, 2'b00,2'b01,2'b10, 3'b000, rnd());
        push(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, rnd());
      end
      7'b0110111: push(0,0,0,0,0,1,0, 2'b11,2'b00,2'b00, 3'b000, rnd());
      default: push_fault();
    endcase
  endtask

  task automatic play(input logic rdy, output logic [18:0] o);
    mem_ready = rdy;
    #1;
    o = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f75, input logic z);
    op = o; funct3 = f3; funct7_5 = f75; zero = z;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    set_instr(7'b0000011, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    exp = {7'b0000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs, exp);
    end
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp = {7'b1000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_directed();
    logic [18:0] o;
    ent_t e;
    int cyc;
    // lw ready held high, sw with 3-cycle wait, beq taken/untaken,
    // add/sub/addi with funct7_5, jal, lui, and a wait of exactly TO cycles
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0); model_instr(0, 0);
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0); model_instr(0, 3);
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1); model_instr(0, 0);
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0); model_instr(0, 0);
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0); model_instr(0, 0);
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0); model_instr(0, 0);
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0); model_instr(0, 0);
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0); model_instr(1, 0);
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0); model_instr(2, 0);
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0); model_instr(TO, TO);
    // the queue holds one entry per cycle; replay instruction by instruction
    cyc = 0;
    q = {};
    foreach (dir_ops[k]) begin
      set_instr(dir_ops[k], dir_f3[k], dir_f75[k], dir_z[k]);
      model_instr(dir_df[k], dir_dm[k]);
      while (q.size() > 0) begin
        e = q.pop_front();
        play(e.rdy, o);
        checks++;
        if (o !== e.exp) begin
          failures++;
          $display("FAIL directed_%0d cyc=%0d op=%b got=%h exp=%h", k, cyc, op, o, e.exp);
        end
        cyc++;
      end
    end
  endtask

  logic [6:0] dir_ops [10] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011,
                               7'b0110011, 7'b0110011, 7'b0010011, 7'b1101111,
                               7'b0110111, 7'b0000011};
  logic [2:0] dir_f3  [10] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b010};
  logic       dir_f75 [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
  logic       dir_z   [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int         dir_df  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, TO};
  int         dir_dm  [10] = '{0, 3, 0, 0, 0, 0, 0, 0, 0, TO};

  task automatic test_timeout();
    logic [18:0] o, exp;
    ent_t e;
    int cyc;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    q = {};
    for (int i = 0; i <= TO; i++) push(1,0,0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 1'b0);
    push(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 1'b0);
    push_fault();
    push_fault();
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      play(e.rdy, o);
      checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, o, e.exp);
      end
      cyc++;
    end
    do_reset();
    #1;
    exp = {7'b1000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL timeout_reset got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_illegal();
    logic [18:0] o;
    ent_t e;
    logic [6:0] ops [3] = '{7'b1111111, 7'b1100011, 7'b1100011};
    logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b100};
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], f3s[k], 1'b0, 1'b0);
      q = {};
      model_instr(0, 0);
      if (q[q.size()-1].exp[12] === 1'b1) push_fault();
      while (q.size() > 0) begin
        e = q.pop_front();
        play(e.rdy, o);
        checks++;
        if (o !== e.exp) begin
          failures++;
          $display("FAIL illegal_%0d op=%b f3=%b got=%h exp=%h", k, op, funct3, o, e.exp);
        end
      end
      do_reset();
    end
  endtask

  task automatic test_random();
    logic [18:0] o;
    ent_t e;
    logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b0110111};
    logic [6:0] rop;
    logic [2:0] rf3;
    for (int n = 0; n < 60; n++) begin
      rop = legal_ops[$urandom_range(6, 0)];
      rf3 = 3'($urandom_range(7, 0));
      if (rop == 7'b1100011) rf3 = EXT ? 3'($urandom_range(1, 0)) : 3'b000;
      set_instr(rop, rf3, rnd(), rnd());
      q = {};
      model_instr(int'($urandom_range(TO, 0)), int'($urandom_range(TO, 0)));
      while (q.size() > 0) begin
        e = q.pop_front();
        play(e.rdy, o);
        checks++;
        if (o !== e.exp) begin
          failures++;
          $display("FAIL random_%0d op=%b f3=%b f75=%b z=%b got=%h exp=%h",
                   n, op, funct3, funct7_5, zero, o, e.exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    set_instr(7'b0, 3'b0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_timeout();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
